// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: push/pop handshake and status bundle
// for the parametrised synchronous FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int CW     = $clog2(DEPTH + 1)
);
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output push, data_in, pop, clr_err,
    input  data_out, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, clr_err,
    output data_out, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: any-depth synchronous FIFO with registered
// or first-word-fall-through read, occupancy and sticky errors.
module sync_fifo_param #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  sync_fifo_param_if.slave fifo
);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL out of range");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL out of range");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;

  // status is decoded from the registered count only
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign pop_ok  = fifo.pop && !empty;
  assign push_ok = fifo.push && (!full || pop_ok);

  assign fifo.full         = full;
  assign fifo.empty        = empty;
  assign fifo.almost_full  = (count >= CW'(AF_LEVEL));
  assign fifo.almost_empty = (count <= CW'(AE_LEVEL));
  assign fifo.count        = count;
  assign fifo.overflow     = overflow;
  assign fifo.underflow    = underflow;

  // storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= fifo.data_in;
  end

  // pointers wrap explicitly at DEPTH-1, occupancy tracks accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // sticky errors; a new error in the clearing cycle wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fifo.push && !push_ok) overflow <= 1'b1;
      else if (fifo.clr_err)     overflow <= 1'b0;
      if (fifo.pop && empty)     underflow <= 1'b1;
      else if (fifo.clr_err)     underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign fifo.data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_reg
    logic [DATA_W-1:0] data_q;

    // registered read: capture head word on each accepted pop
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      data_q <= '0;
      else if (pop_ok) data_q <= mem[rd_ptr];
    end

    assign fifo.data_out = data_q;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed vectors for registered-read and
// FWFT instances of sync_fifo_param (DEPTH=5, DATA_W=8).
module tb_sync_fifo_param;
  localparam int DW = 8;
  localparam int DP = 5;

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] din;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ov;
    logic       un;
    logic [7:0] dout;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs[$];
  logic [7:0] q[$];

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) f0 ();
  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) f1 ();

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .FWFT(0),
    .AF_LEVEL(4), .AE_LEVEL(1)
  ) u_reg (
    .clk(clk), .rst_n(rst_n), .fifo(f0)
  );

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .FWFT(1),
    .AF_LEVEL(4), .AE_LEVEL(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .fifo(f1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(
    input logic p, input logic o, input logic c,
    input logic [7:0] d, input int n,
    input logic fu, input logic em, input logic af,
    input logic ae, input logic ov, input logic un,
    input logic [7:0] dq
  );
    vec_t v;
    v.push = p; v.pop = o; v.clr = c; v.din = d;
    v.cnt = n; v.full = fu; v.empty = em; v.af = af;
    v.ae = ae; v.ov = ov; v.un = un; v.dout = dq;
    vecs.push_back(v);
  endtask

  task automatic drive0(input logic p, input logic o,
                        input logic c, input logic [7:0] d);
    f0.push = p; f0.pop = o; f0.clr_err = c; f0.data_in = d;
  endtask

  task automatic drive1(input logic p, input logic o,
                        input logic [7:0] d);
    f1.push = p; f1.pop = o; f1.data_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"},   int'(f0.count), 0);
    chk({tag, "_empty"}, int'(f0.empty), 1);
    chk({tag, "_full"},  int'(f0.full), 0);
    chk({tag, "_ae"},    int'(f0.almost_empty), 1);
    chk({tag, "_af"},    int'(f0.almost_full), 0);
    chk({tag, "_ov"},    int'(f0.overflow), 0);
    chk({tag, "_un"},    int'(f0.underflow), 0);
    chk({tag, "_dout"},  int'(f0.data_out), 0);
    chk({tag, "_fdout"}, int'(f1.data_out), 0);
    chk({tag, "_fempty"}, int'(f1.empty), 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive0(0, 0, 0, 8'h00);
    drive1(0, 0, 8'h00);
    f1.clr_err = 1'b0;

    //             p o c din  n  fu em af ae ov un dout
    add(1, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    add(1, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 8'h33, 3, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 8'h44, 4, 0, 0, 1, 0, 0, 0, 8'h00);
    add(1, 0, 0, 8'h55, 5, 1, 0, 1, 0, 0, 0, 8'h00);
    add(1, 0, 0, 8'h66, 5, 1, 0, 1, 0, 1, 0, 8'h00);
    add(0, 0, 1, 8'h00, 5, 1, 0, 1, 0, 0, 0, 8'h00);
    add(1, 1, 0, 8'hAA, 5, 1, 0, 1, 0, 0, 0, 8'h11);
    add(0, 1, 0, 8'h00, 4, 0, 0, 1, 0, 0, 0, 8'h22);
    add(0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 0, 0, 8'h33);
    add(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0, 8'h44);
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h55);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'hAA);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 8'hAA);
    add(1, 1, 0, 8'h07, 1, 0, 0, 0, 1, 0, 1, 8'hAA);
    add(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'hAA);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h07);
    add(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 8'h07);
    add(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h07);

    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive0(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
      tick();
      chk($sformatf("v%0d_cnt", i), int'(f0.count), vecs[i].cnt);
      chk($sformatf("v%0d_full", i), int'(f0.full), int'(vecs[i].full));
      chk($sformatf("v%0d_empty", i), int'(f0.empty), int'(vecs[i].empty));
      chk($sformatf("v%0d_af", i), int'(f0.almost_full), int'(vecs[i].af));
      chk($sformatf("v%0d_ae", i), int'(f0.almost_empty), int'(vecs[i].ae));
      chk($sformatf("v%0d_ov", i), int'(f0.overflow), int'(vecs[i].ov));
      chk($sformatf("v%0d_un", i), int'(f0.underflow), int'(vecs[i].un));
      chk($sformatf("v%0d_dout", i), int'(f0.data_out), int'(vecs[i].dout));
    end
    drive0(0, 0, 0, 8'h00);

    // sustained push+pop at occupancy 3, wrapping pointers twice
    for (int i = 0; i < 3; i++) begin
      drive0(1, 0, 0, 8'h80 + 8'(i));
      q.push_back(8'h80 + 8'(i));
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] exp;
      drive0(1, 1, 0, 8'h90 + 8'(i));
      q.push_back(8'h90 + 8'(i));
      exp = q.pop_front();
      tick();
      chk($sformatf("wrap%0d_dout", i), int'(f0.data_out), int'(exp));
      chk($sformatf("wrap%0d_cnt", i), int'(f0.count), 3);
    end
    drive0(0, 0, 0, 8'h00);

    // FWFT: word visible right after its push edge, zero when empty
    drive1(1, 0, 8'h3C);
    tick();
    chk("fw_dout1", int'(f1.data_out), 8'h3C);
    chk("fw_empty1", int'(f1.empty), 0);
    drive1(1, 0, 8'h4D);
    tick();
    chk("fw_dout2", int'(f1.data_out), 8'h3C);
    chk("fw_cnt2", int'(f1.count), 2);
    drive1(0, 1, 8'h00);
    tick();
    chk("fw_dout3", int'(f1.data_out), 8'h4D);
    tick();
    chk("fw_empty4", int'(f1.empty), 1);
    chk("fw_dout4", int'(f1.data_out), 0);
    drive1(0, 0, 8'h00);

    // asynchronous reset in the middle of filling
    drive0(1, 0, 0, 8'hB0);
    drive1(1, 0, 8'hC0);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    drive0(0, 0, 0, 8'h00);
    drive1(0, 0, 8'h00);
    tick();
    rst_n = 1'b1;
    drive0(1, 0, 0, 8'h5A);
    drive1(1, 0, 8'h6B);
    tick();
    chk("post_cnt", int'(f0.count), 1);
    chk("post_fdout", int'(f1.data_out), 8'h6B);
    drive0(0, 1, 0, 8'h00);
    drive1(0, 0, 8'h00);
    tick();
    chk("post_dout", int'(f0.data_out), 8'h5A);
    chk("post_empty", int'(f0.empty), 1);
    drive0(0, 0, 0, 8'h00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO that replaces the fixed power-of-two FIFO in the generic elements library. It accepts any depth ≥ 2 and allows a push and a pop in the same cycle, including when the FIFO is full. It offers a standard registered-read mode and a first-word-fall-through (FWFT) mode, plus occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between protocol front-ends and downstream consumers as the common buffering element.

## Interface
- DATA_W, 64, data word width in bits (≥ 1)
- DEPTH, 8, number of storage entries; any integer ≥ 2, power of two not required
- FWFT, 0, 0 = registered read (data on the edge after pop), 1 = first-word-fall-through
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL
- CW, $clog2(DEPTH+1), derived width of the count output; do not override

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- push, input, 1, write request
- data_in, input, DATA_W, write data, sampled on an accepted push
- pop, input, 1, read request
- data_out, output, DATA_W, read data (mode dependent, see Operation)
- full, output, 1, count == DEPTH
- empty, output, 1, count == 0
- almost_full, output, 1, count ≥ AF_LEVEL
- almost_empty, output, 1, count ≤ AE_LEVEL
- count, output, CW, current occupancy, 0..DEPTH
- overflow, output, 1, sticky: a push was rejected
- underflow, output, 1, sticky: a pop was rejected
- clr_err, input, 1, synchronous clear of overflow and underflow

## Operation
- Storage: DEPTH × DATA_W array. Write pointer wr_ptr and read pointer rd_ptr each range 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. No masking arithmetic.
- Acceptance rules:
  - pop_ok = pop && !empty.
  - push_ok = push && (!full || pop_ok).
  - A push to a full FIFO with a simultaneous pop succeeds, and count is unchanged.
  - A pop on an empty FIFO is rejected even with a simultaneous push; the pushed word is stored.
- count next value:
  - +1 on push_ok only.
  - −1 on pop_ok only.
  - Unchanged when both or neither are accepted.
- Error flags:
  - overflow sets on push && !push_ok.
  - underflow sets on pop && empty.
  - Both hold until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the flag is set (set wins).
- FWFT=0:
  - On pop_ok, data_out registers mem[rd_ptr] at that edge.
  - Otherwise data_out holds its last value.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally while !empty, and all zeros while empty.
  - pop_ok advances to the next word.
- full, empty, almost_full and almost_empty are decoded from the registered count only. They are never combinational from push or pop.
- Memory contents are not reset.
- Elaboration error conditions:
  - DEPTH < 2.
  - AF_LEVEL outside 1..DEPTH.
  - AE_LEVEL outside 0..DEPTH-1.

## Timing
- Reset values: data_out 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (1 only if AF_LEVEL == 0, which is illegal), overflow 0, underflow 0. Pointers are 0.
- Reset mid-operation discards all contents immediately. The first push after reset deassertion is written to entry 0.
- Status flags and count update on the clock edge that accepts the push or pop. They are visible in the following cycle.
- FWFT=0 read latency: pop in cycle N → data_out valid after edge N, stable until the next pop_ok.
- FWFT=1 latency: a word pushed into an empty FIFO at edge N appears on data_out, with empty=0, after edge N. There is no bypass in the same cycle.
- Throughput: one push and one pop per cycle, sustained, at any occupancy.

## Test plan
- Reset, then DEPTH=5, FWFT=0: push 0x11..0x55 → full=1, count=5. A 6th push → overflow=1 and count stays 5. Five pops → data_out 0x11..0x55 in order, then empty=1.
- DEPTH=5: 12 push/pop pairs crossing the pointer wrap twice → data order preserved and count stays constant.
- Full FIFO with simultaneous push 0xAA and pop → count stays 5, no overflow. 0xAA is read out last.
- Empty FIFO with simultaneous push 0x7 and pop → underflow=1, count=1, and 0x7 is read by the next pop.
- FWFT=1: push 0x3C at edge N → data_out=0x3C after edge N with no pop. Pop → empty=1 and data_out=0.
- AF_LEVEL=4, AE_LEVEL=1: fill 0→5 then drain → almost_full at count 4 and 5, almost_empty at count 0 and 1. clr_err clears the sticky flags, and asserting rst_n low mid-fill returns all outputs to their reset values.
